prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the instruction-memory interface: receives a program as a byte stream and writes 32-bit words into instruction memory.
- Holds the processor core in reset while a load is in progress.
- Sits between a byte source (UART receiver or testbench) and the write port of the instruction memory.
- Releases the core only after a complete, checksum-verified image has been written.

Parameters:
- ADDR_W, 4, instruction-memory word-address width; depth DEPTH = 2**ADDR_W words.
- TIMEOUT, 1000000, max idle cycles between bytes inside a frame before error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-source data valid.
- in_data  in  8  byte-source data.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready at the clk edge.
- load_req  in  1  one-cycle pulse; starts a new load from DONE or ERR.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  instruction-memory word address.
- imem_wd  out  32  instruction-memory write data.
- cpu_rst_n  out  1  core reset, active low; low while not DONE.
- done  out  1  image loaded and verified.
- err  out  1  load failed: oversize, checksum mismatch or timeout.

Behaviour:
- Frame format: LEN_LO, LEN_HI (word count N, 16 bits, little-endian), then 4*N data bytes (each word little-endian: first byte -> imem_wd[7:0]), then CHK byte.
- CHK = 8-bit sum mod 256 of all 4*N data bytes. Length bytes are excluded.
- Reset state: LEN_LO.
- Reset values: in_ready=1, imem_we=0, imem_addr=0, imem_wd=0, cpu_rst_n=0, done=0, err=0.
- Internal state is cleared on reset: word counter, byte index (2 bits), checksum accumulator, timeout counter.
- LEN_LO: in_ready=1. On accept, store the low byte and go to LEN_HI.
- LEN_HI: in_ready=1. On accept, form N.
  - If N > DEPTH, go to ERR.
  - Else if N==0, go to CHK.
  - Else go to DATA with addr=0, byte index=0.
- DATA: in_ready=1. On accept:
  - Place the byte into the assembly register at lane [byte index].
  - Add the byte to the checksum.
  - On the 4th byte, go to WRITE.
- WRITE: exactly one cycle.
  - Outputs: imem_we=1, imem_addr=current word address, imem_wd=assembled word, in_ready=0.
  - Next cycle: address increments.
  - If N words have been written, go to CHK; else go to DATA.
  - The write appears one cycle after the 4th byte is accepted.
- CHK: in_ready=1. On accept, compare the byte with the accumulator.
  - Match: go to DONE.
  - Mismatch: go to ERR.
- DONE: done=1, cpu_rst_n=1 (registered, asserted the cycle after CHK accept), in_ready=0.
- ERR: err=1, cpu_rst_n=0, in_ready=0.
- load_req in DONE or ERR:
  - Next cycle: state LEN_LO; done, err and cpu_rst_n=0; counters and checksum cleared.
  - load_req is ignored in all other states.
- Timeout:
  - Counter increments each cycle in LEN_HI, DATA and CHK while no byte is accepted.
  - It clears on every accept and is inactive in LEN_LO.
  - Reaching TIMEOUT goes to ERR; no further writes are issued.
- Boundaries:
  - N==DEPTH is legal; the final address is DEPTH-1 and the address counter must not wrap before the last write.
  - Partial word at timeout: no write.
  - in_valid while in_ready=0: the byte is not consumed; the source holds it.
- Reset mid-load: everything returns to reset values and state LEN_LO. Memory contents are not cleared; cpu_rst_n stays low.
- imem_addr and imem_wd hold their last values when imem_we=0.
- All outputs are registered.

Decomposition:
- Shared package (riscv_pkg):
  - State encoding enum: LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR.
  - Default ADDR_W constant.
- Natural sub-module: byte_packer.
  - Contents: 2-bit lane index, 32-bit shift/assembly register, word_ready flag.
  - The FSM, address counter, checksum and timeout stay in prog_loader.

Test Plan:
- Bytes 02,00, 13,00,10,00, 93,00,20,00, CHK=D6 -> writes addr0=00100013, addr1=00200093; done=1, cpu_rst_n=1, err=0.
- Same frame with CHK=D5 -> both writes occur, then err=1, done=0, cpu_rst_n=0.
- LEN=0x0011 with ADDR_W=4 -> err=1 immediately after LEN_HI; no imem_we pulses.
- N=16, 64 bytes then correct CHK -> 16 writes, addr 0..15 in order, last addr=15, done=1.
- TIMEOUT=8; send LEN and 2 data bytes then idle -> err=1 exactly 8 cycles after the last accept; no write.
- Byte source toggles in_valid randomly; also assert rst low mid-DATA -> outputs return to reset values, then a full reload with load_req not needed succeeds; load_req from DONE starts a second load that overwrites addr0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the program loader: loader FSM state encoding and
// the default instruction-memory address width.
package riscv_pkg;

  localparam int DEFAULT_ADDR_W = 4;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } load_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word. The word output
// already includes the byte being offered, so the caller can capture it on the
// same edge that accepts the fourth byte.
module byte_packer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  lane;
  logic [31:0] assembly;

  always_comb begin
    word = assembly;
    word[{lane, 3'b000} +: 8] = data;
    word_ready = en && (lane == 2'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane     <= 2'd0;
      assembly <= 32'd0;
    end else if (clear) begin
      lane     <= 2'd0;
      assembly <= 32'd0;
    end else if (en) begin
      lane     <= lane + 2'd1;
      assembly <= word;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a length/data/checksum frame, writes the
// words into instruction memory and holds the core in reset until verified.
module prog_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  load_state_t state, next_state;

  logic [7:0]      len_lo;
  logic [15:0]     len_full;
  logic [ADDR_W:0] n_words;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] word_cnt_inc;
  logic [7:0]      chk_acc;
  logic [TO_W-1:0] to_cnt;

  logic        accept;
  logic        cnt_active;
  logic        timeout_hit;
  logic        restart;
  logic        pack_en;
  logic        pack_clear;
  logic [31:0] pack_word;
  logic        pack_last;

  assign accept       = in_valid && in_ready;
  assign len_full     = {in_data, len_lo};
  assign word_cnt_inc = word_cnt + CNT_ONE;
  assign cnt_active   = (state == S_LEN_HI) || (state == S_DATA) || (state == S_CHK);
  assign timeout_hit  = (TIMEOUT != 0) && cnt_active && !accept && (to_cnt == TO_LAST);
  assign restart      = load_req && ((state == S_DONE) || (state == S_ERR));
  assign pack_en      = accept && (state == S_DATA);
  assign pack_clear   = restart || (accept && (state == S_LEN_HI));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .en         (pack_en),
    .data       (in_data),
    .word       (pack_word),
    .word_ready (pack_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LEN_LO;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_LEN_LO: if (accept) next_state = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (32'(len_full) > DEPTH) next_state = S_ERR;
          else if (len_full == 16'd0) next_state = S_CHK;
          else next_state = S_DATA;
        end
      end
      S_DATA:  if (pack_last) next_state = S_WRITE;
      S_WRITE: next_state = (word_cnt_inc == n_words) ? S_CHK : S_DATA;
      S_CHK: begin
        if (accept) next_state = (in_data == chk_acc) ? S_DONE : S_ERR;
      end
      S_DONE:  if (load_req) next_state = S_LEN_LO;
      S_ERR:   if (load_req) next_state = S_LEN_LO;
      default: next_state = S_LEN_LO;
    endcase
    if (timeout_hit) next_state = S_ERR;
  end

  // Outputs are registered from next_state so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b1;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= 32'd0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                   (next_state == S_DATA)   || (next_state == S_CHK);
      imem_we   <= (next_state == S_WRITE);
      cpu_rst_n <= (next_state == S_DONE);
      done      <= (next_state == S_DONE);
      err       <= (next_state == S_ERR);
      if (next_state == S_WRITE) begin
        imem_addr <= word_cnt[ADDR_W-1:0];
        imem_wd   <= pack_word;
      end
    end
  end

  // word_cnt is one bit wider than the address so a full-depth image ends cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo   <= 8'd0;
      n_words  <= '0;
      word_cnt <= '0;
      chk_acc  <= 8'd0;
    end else if (restart) begin
      len_lo   <= 8'd0;
      n_words  <= '0;
      word_cnt <= '0;
      chk_acc  <= 8'd0;
    end else begin
      if (accept && (state == S_LEN_LO)) len_lo <= in_data;
      if (accept && (state == S_LEN_HI)) begin
        n_words  <= (ADDR_W + 1)'(len_full);
        word_cnt <= '0;
        chk_acc  <= 8'd0;
      end
      if (pack_en) chk_acc <= chk_acc + in_data;
      if (state == S_WRITE) word_cnt <= word_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (accept || !cnt_active) begin
      to_cnt <= '0;
    end else if (TIMEOUT != 0) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of whole frames plus hand-written
// sequences for full depth, timeout, mid-load reset and reload.
module tb_prog_loader;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              load_req = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .load_req  (load_req),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [31:0]       mem[DEPTH];

  // Write monitor on the falling edge, away from the registered output updates.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wd);
      mem[imem_addr] = imem_wd;
    end
  end

  typedef struct {
    logic [7:0]  bytes [12];
    int          nbytes;
    int          exp_writes;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit random_gap);
    int waited;
    int gap;
    logic acc;
    if (random_gap) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        in_data = 8'($urandom);
        tick();
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      acc = in_ready;
      tick();
      if (acc) break;
      waited++;
      if (waited > 50) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL send_timeout: byte %h not accepted, in_ready=%b", b, in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check_output("reload_in_ready", in_ready, 1);
    check_output("reload_done", done, 0);
    check_output("reload_err", err, 0);
    check_output("reload_cpu_rst_n", cpu_rst_n, 0);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic apply_stimulus(input int i);
    if (i > 0) pulse_load();
    clear_log();
    for (int k = 0; k < vecs[i].nbytes; k++) send_byte(vecs[i].bytes[k], 1'b0);
    check_output($sformatf("v%0d_done", i), done, vecs[i].exp_done);
    check_output($sformatf("v%0d_err", i), err, vecs[i].exp_err);
    check_output($sformatf("v%0d_cpu_rst_n", i), cpu_rst_n, vecs[i].exp_done);
    check_output($sformatf("v%0d_in_ready", i), in_ready, 0);
    repeat (2) tick();
    check_output($sformatf("v%0d_nwrites", i), wr_data_q.size(), vecs[i].exp_writes);
    if (vecs[i].exp_writes > 0 && wr_data_q.size() > 0) begin
      check_output($sformatf("v%0d_addr0", i), wr_addr_q[0], 0);
      check_output($sformatf("v%0d_data0", i), wr_data_q[0], vecs[i].exp_w0);
    end
    if (vecs[i].exp_writes > 1 && wr_data_q.size() > 1) begin
      check_output($sformatf("v%0d_addr1", i), wr_addr_q[1], 1);
      check_output($sformatf("v%0d_data1", i), wr_data_q[1], vecs[i].exp_w1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"}, in_ready, 1);
    check_output({tag, "_imem_we"}, imem_we, 0);
    check_output({tag, "_imem_addr"}, imem_addr, 0);
    check_output({tag, "_imem_wd"}, imem_wd, 0);
    check_output({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_err"}, err, 0);
  endtask

  initial begin
    logic [7:0]  wb;
    logic [7:0]  chk;
    logic [31:0] word;

    vecs[0].bytes = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00,
                      8'h20, 8'h00, 8'hD6, 8'h00};
    vecs[0].nbytes = 11; vecs[0].exp_writes = 2;
    vecs[0].exp_w0 = 32'h00100013; vecs[0].exp_w1 = 32'h00200093;
    vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0;

    vecs[1] = vecs[0];
    vecs[1].bytes[10] = 8'hD5;
    vecs[1].exp_done = 1'b0; vecs[1].exp_err = 1'b1;

    vecs[2].bytes = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].nbytes = 2; vecs[2].exp_writes = 0;
    vecs[2].exp_w0 = 32'h0; vecs[2].exp_w1 = 32'h0;
    vecs[2].exp_done = 1'b0; vecs[2].exp_err = 1'b1;

    vecs[3].bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].nbytes = 3; vecs[3].exp_writes = 0;
    vecs[3].exp_w0 = 32'h0; vecs[3].exp_w1 = 32'h0;
    vecs[3].exp_done = 1'b1; vecs[3].exp_err = 1'b0;

    vecs[4].bytes = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4].nbytes = 7; vecs[4].exp_writes = 1;
    vecs[4].exp_w0 = 32'hDEADBEEF; vecs[4].exp_w1 = 32'h0;
    vecs[4].exp_done = 1'b1; vecs[4].exp_err = 1'b0;

    vecs[5].bytes = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5].nbytes = 2; vecs[5].exp_writes = 0;
    vecs[5].exp_w0 = 32'h0; vecs[5].exp_w1 = 32'h0;
    vecs[5].exp_done = 1'b0; vecs[5].exp_err = 1'b1;

    $display("[TB] start");
    #12;
    check_reset_values("por");
    tick();
    rst = 1'b1;
    tick();
    check_reset_values("post_por");

    for (int i = 0; i < 6; i++) apply_stimulus(i);

    // Full-depth image: 16 words, addresses must run 0..15 without wrapping.
    pulse_load();
    clear_log();
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    chk = 8'h00;
    for (int w = 0; w < DEPTH; w++) begin
      word = {8'(w * 7), 8'hC3, 8'(w), 8'(8'h10 + w)};
      for (int b = 0; b < 4; b++) begin
        wb  = word[b*8 +: 8];
        chk = chk + wb;
        send_byte(wb, 1'b0);
      end
    end
    send_byte(chk, 1'b0);
    check_output("full_done", done, 1);
    check_output("full_err", err, 0);
    check_output("full_nwrites", wr_data_q.size(), DEPTH);
    for (int w = 0; w < DEPTH && w < wr_data_q.size(); w++) begin
      word = {8'(w * 7), 8'hC3, 8'(w), 8'(8'h10 + w)};
      check_output($sformatf("full_addr%0d", w), wr_addr_q[w], w);
      check_output($sformatf("full_data%0d", w), wr_data_q[w], word);
    end

    // Timeout: two data bytes of a three-word frame, then silence.
    pulse_load();
    clear_log();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    repeat (TIMEOUT - 1) tick();
    check_output("to_err_early", err, 0);
    check_output("to_ready_early", in_ready, 1);
    tick();
    check_output("to_err", err, 1);
    check_output("to_ready", in_ready, 0);
    check_output("to_cpu_rst_n", cpu_rst_n, 0);
    repeat (3) tick();
    check_output("to_nwrites", wr_data_q.size(), 0);

    // Mid-DATA reset with a gappy source, then reload without load_req.
    pulse_load();
    clear_log();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    check_output("midrst_nwrites", wr_data_q.size(), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_output("rel_cpu_rst_n", cpu_rst_n, 0);
    check_output("rel_in_ready", in_ready, 1);
    for (int k = 0; k < vecs[0].nbytes; k++) send_byte(vecs[0].bytes[k], 1'b1);
    check_output("reload_ok_done", done, 1);
    check_output("reload_ok_cpu_rst_n", cpu_rst_n, 1);
    check_output("reload_ok_nwrites", wr_data_q.size(), 2);
    check_output("reload_ok_mem1", mem[1], 32'h00200093);

    // Second load from DONE overwrites word 0 only.
    pulse_load();
    clear_log();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h14, 1'b1);
    check_output("second_done", done, 1);
    check_output("second_nwrites", wr_data_q.size(), 1);
    check_output("second_mem0", mem[0], 32'h12345678);
    check_output("second_mem1", mem[1], 32'h00200093);
    check_output("second_hold_addr", imem_addr, 0);
    check_output("second_hold_wd", imem_wd, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
